// File: rtl/fsm_pattern_detector_if.sv
// Bus bundle for fsm_pattern_detector: serial input stream, pattern reload,
// counter clear, and the match outputs.
// The master modport drives the stream; the slave modport is the detector.
interface fsm_pattern_detector_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             data_in;
    logic             data_valid;
    logic             overlap_en;
    logic             pat_wr;
    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] mask_in;
    logic             count_clr;
    logic             detected;
    logic [CNT_W-1:0] match_count;

    modport master (
        output data_in, data_valid, overlap_en, pat_wr, pat_in, mask_in, count_clr,
        input  detected, match_count
    );

    modport slave (
        input  data_in, data_valid, overlap_en, pat_wr, pat_in, mask_in, count_clr,
        output detected, match_count
    );
endinterface

// File: rtl/fsm_pattern_detector.sv
// Serial bit-stream pattern detector with run-time pattern/mask reload,
// overlapping or non-overlapping matching and an optional saturating counter.
// Build option: define PAT_DETECT_COUNT_EN to include the match counter;
// without it match_count is tied to zero and count_clr is ignored.
module fsm_pattern_detector #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int unsigned      CNT_W   = 8
) (
    input logic                  clk,
    input logic                  reset,
    fsm_pattern_detector_if.slave bus
);
    localparam int unsigned      FillW    = $clog2(PAT_W + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

    typedef enum logic [1:0] {StIdle, StFilling, StArmed} state_e;

    state_e           state_q;
    logic [PAT_W-1:0] history_q;
    logic [PAT_W-1:0] pattern_q;
    logic [PAT_W-1:0] mask_q;
    logic [FillW-1:0] fill_q;
    logic             detected_q;

    logic             consume;
    logic [PAT_W-1:0] shift_d;
    logic [FillW-1:0] fill_d;
    logic             match_d;

    // Candidate history/fill after accepting the current bit, and the match test on it.
    always_comb begin
        consume = bus.data_valid & ~bus.pat_wr;
        shift_d = {history_q[PAT_W-2:0], bus.data_in};
        fill_d  = (state_q == StArmed) ? FillFull : fill_q + 1'b1;
        match_d = consume && (fill_d == FillFull) &&
                  (((shift_d ^ pattern_q) & mask_q) == '0);
    end

    // Detector FSM: reset, pattern reload, then consume steps; detected is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            history_q  <= '0;
            fill_q     <= '0;
            pattern_q  <= PATTERN;
            mask_q     <= '1;
            detected_q <= 1'b0;
        end else if (bus.pat_wr) begin
            // Reload restarts matching; the bit on this edge is dropped.
            state_q    <= StIdle;
            history_q  <= '0;
            fill_q     <= '0;
            pattern_q  <= bus.pat_in;
            mask_q     <= bus.mask_in;
            detected_q <= 1'b0;
        end else if (bus.data_valid) begin
            detected_q <= match_d;
            if (match_d && !bus.overlap_en) begin
                state_q   <= StIdle;
                history_q <= '0;
                fill_q    <= '0;
            end else begin
                state_q   <= (fill_d == FillFull) ? StArmed : StFilling;
                history_q <= shift_d;
                fill_q    <= fill_d;
            end
        end else begin
            detected_q <= 1'b0;
        end
    end

    assign bus.detected = detected_q;

`ifdef PAT_DETECT_COUNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] count_q;

    // Saturating match counter; a clear beats a simultaneous match.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (bus.count_clr) begin
            count_q <= '0;
        end else if (match_d && (count_q != CntMax)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.match_count = count_q;
`else
    logic unused_count_clr;

    assign unused_count_clr = bus.count_clr;
    assign bus.match_count  = '0;
`endif
endmodule
